// File: rtl/uartprobe_pkg.sv
// rtl/uartprobe_pkg.sv - shared command field layout, opcodes and state encoding for the UART probe
package uartprobe_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_GPI_RD = 2'b01,
      OP_GPO_RD = 2'b10,
      OP_GPO_WR = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_RDATA = 2'd2
   } state_e;

   // Command byte: [7:6] opcode, [5:4] ignored, [3:2] length-1, [1:0] start lane
   localparam int unsigned CMD_OP_MSB   = 7;
   localparam int unsigned CMD_OP_LSB   = 6;
   localparam int unsigned CMD_LEN_MSB  = 3;
   localparam int unsigned CMD_LEN_LSB  = 2;
   localparam int unsigned CMD_LANE_MSB = 1;
   localparam int unsigned CMD_LANE_LSB = 0;

   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/uartprobe_timeout.sv
// rtl/uartprobe_timeout.sv - idle-cycle watchdog; expires on the TIMEOUT_CYCLES-th consecutive idle cycle
module uartprobe_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // expire_o must not depend on clear_i: the caller derives clear_i from !expire_o
   assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!enable_i || clear_i || expire_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uartprobe_cmd_ctrl.sv
// rtl/uartprobe_cmd_ctrl.sv - UART byte command controller reading GPI/GPO and writing GPO byte lanes
module uartprobe_cmd_ctrl
   import uartprobe_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic [31:0] gpi_val,
   input  logic [31:0] gpo_val,
   output logic        gpo_wr_en,
   output logic [1:0]  gpo_wr_addr,
   output logic [7:0]  gpo_wr_data,
   output logic        busy,
   output logic        err_timeout
);
   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] snap_q, snap_d;
   logic        wr_en_q, wr_en_d;
   logic [1:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        err_q, err_d;
   logic        rx_ready_c, tx_valid_c;
   logic [7:0]  tx_data_c;
   logic        expire, wdata_active, wdata_fire;
   opcode_e     op;

   assign op           = opcode_e'(rx_data[CMD_OP_MSB:CMD_OP_LSB]);
   assign wdata_active = (state_q == ST_WDATA);
   assign wdata_fire   = wdata_active && rx_valid && !expire;

   uartprobe_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (wdata_fire),
      .enable_i(wdata_active),
      .expire_o(expire)
   );

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      cnt_d      = cnt_q;
      snap_d     = snap_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_d      = 1'b0;
      rx_ready_c = 1'b0;
      tx_valid_c = 1'b0;
      tx_data_c  = 8'h00;
      case (state_q)
         ST_IDLE: begin
            rx_ready_c = 1'b1;
            if (rx_valid) begin
               case (op)
                  OP_GPI_RD, OP_GPO_RD: begin
                     snap_d  = (op == OP_GPI_RD) ? gpi_val : gpo_val;
                     lane_d  = rx_data[CMD_LANE_MSB:CMD_LANE_LSB];
                     cnt_d   = rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
                     state_d = ST_RDATA;
                  end
                  OP_GPO_WR: begin
                     lane_d  = rx_data[CMD_LANE_MSB:CMD_LANE_LSB];
                     cnt_d   = rx_data[CMD_LEN_MSB:CMD_LEN_LSB];
                     state_d = ST_WDATA;
                  end
                  default: ;
               endcase
            end
         end
         ST_WDATA: begin
            // Timeout wins over a byte arriving in the same cycle
            rx_ready_c = !expire;
            if (expire) begin
               err_d   = 1'b1;
               cnt_d   = 2'd0;
               state_d = ST_IDLE;
            end else if (rx_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = lane_q;
               wr_data_d = rx_data;
               lane_d    = lane_q + 2'd1;
               if (cnt_q == 2'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
         end
         ST_RDATA: begin
            tx_valid_c = 1'b1;
            tx_data_c  = lane_byte(snap_q, lane_q);
            if (tx_ready) begin
               lane_d = lane_q + 2'd1;
               if (cnt_q == 2'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         lane_q    <= 2'd0;
         cnt_q     <= 2'd0;
         snap_q    <= 32'h0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 2'd0;
         wr_data_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end

   // Reset masks strobes and handshakes immediately, including a strobe pending from the prior edge
   assign rx_ready    = rx_ready_c && !reset;
   assign tx_valid    = tx_valid_c && !reset;
   assign tx_data     = reset ? 8'h00 : tx_data_c;
   assign gpo_wr_en   = wr_en_q && !reset;
   assign gpo_wr_addr = wr_addr_q;
   assign gpo_wr_data = wr_data_q;
   assign busy        = (state_q != ST_IDLE) && !reset;
   assign err_timeout = err_q && !reset;

endmodule

// File: tb/tb_uartprobe_cmd_ctrl.sv
// tb/tb_uartprobe_cmd_ctrl.sv - scoreboard bench for uartprobe_cmd_ctrl
module tb_uartprobe_cmd_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic [31:0] gpi_val = 32'h0;
   logic [31:0] gpo_val = 32'h0;
   logic        gpo_wr_en;
   logic [1:0]  gpo_wr_addr;
   logic [7:0]  gpo_wr_data;
   logic        busy;
   logic        err_timeout;

   int n_checks = 0;
   int n_errors = 0;
   int n_wr = 0;
   int n_tx = 0;
   int n_err = 0;

   logic [9:0] exp_wr[$];
   logic [7:0] exp_tx[$];

   always #5 clk = ~clk;

   uartprobe_cmd_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .gpi_val    (gpi_val),
      .gpo_val    (gpo_val),
      .gpo_wr_en  (gpo_wr_en),
      .gpo_wr_addr(gpo_wr_addr),
      .gpo_wr_data(gpo_wr_data),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: outputs sampled on the falling edge
   always @(negedge clk) begin
      if (gpo_wr_en) begin
         n_wr++;
         if (exp_wr.size() == 0) begin
            check_eq("unexpected_gpo_wr", {22'h0, gpo_wr_addr, gpo_wr_data}, 32'hFFFF_FFFF);
         end else begin
            check_eq("gpo_wr", {22'h0, gpo_wr_addr, gpo_wr_data}, {22'h0, exp_wr.pop_front()});
         end
      end
      if (tx_valid && tx_ready) begin
         n_tx++;
         if (exp_tx.size() == 0) begin
            check_eq("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
         end else begin
            check_eq("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
         end
      end
      if (err_timeout) n_err++;
   end

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bit done = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!done && t < 100) begin
         @(negedge clk);
         if (rx_ready) done = 1'b1;
         @(posedge clk);
         #1;
         t++;
      end
      rx_valid = 1'b0;
      if (!done) check_eq("rx_accept_bound", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      @(negedge clk);
      while (busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_eq(tag, {31'h0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   int wr0, tx0, err0;

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rx_ready", {31'h0, rx_ready}, 32'd0);
      check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
      check_eq("rst_tx_data", {24'h0, tx_data}, 32'd0);
      check_eq("rst_gpo_wr", {21'h0, gpo_wr_en, gpo_wr_addr, gpo_wr_data}, 32'd0);
      check_eq("rst_busy_err", {30'h0, busy, err_timeout}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("post_rst_rx_ready", {31'h0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Write burst, len 4 from lane 0
      exp_wr.push_back({2'd0, 8'h11});
      exp_wr.push_back({2'd1, 8'h22});
      exp_wr.push_back({2'd2, 8'h33});
      exp_wr.push_back({2'd3, 8'h44});
      send_byte(8'hCC);
      check_eq("wr_cmd_busy", {31'h0, busy}, 32'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      @(negedge clk);
      check_eq("wr_done_idle", {31'h0, busy}, 32'd0);
      check_eq("wr_done_rx_ready", {31'h0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_eq("wr_count", n_wr, 32'd4);
      check_eq("wr_queue_empty", exp_wr.size(), 32'd0);

      // GPI read wrapping lane 3 -> lane 0
      gpi_val = 32'hA1B2_C3D4;
      tx0 = n_tx;
      exp_tx.push_back(8'hA1);
      exp_tx.push_back(8'hD4);
      send_byte(8'h47);
      wait_idle("rd_wrap_idle");
      check_eq("rd_wrap_count", n_tx - tx0, 32'd2);
      check_eq("rd_wrap_tx_valid_low", {31'h0, tx_valid}, 32'd0);

      // Backpressure on a GPO read; snapshot must ignore later gpo_val changes
      gpo_val  = 32'h5566_7788;
      tx_ready = 1'b0;
      tx0 = n_tx;
      exp_tx.push_back(8'h88);
      send_byte(8'h80);
      gpo_val = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_tx_valid", {31'h0, tx_valid}, 32'd1);
         check_eq("bp_tx_data", {24'h0, tx_data}, 32'h88);
      end
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      wait_idle("bp_idle");
      check_eq("bp_count", n_tx - tx0, 32'd1);

      // Write burst aborted by timeout after one data byte
      wr0  = n_wr;
      err0 = n_err;
      exp_wr.push_back({2'd0, 8'h5A});
      send_byte(8'hC4);
      send_byte(8'h5A);
      wait_idle("to_idle");
      repeat (3) @(posedge clk);
      #1;
      check_eq("to_err_pulses", n_err - err0, 32'd1);
      check_eq("to_wr_count", n_wr - wr0, 32'd1);
      gpo_val = 32'h0000_00E7;
      tx0 = n_tx;
      exp_tx.push_back(8'hE7);
      send_byte(8'h80);
      wait_idle("to_next_cmd_idle");
      check_eq("to_next_cmd_tx", n_tx - tx0, 32'd1);
      check_eq("to_next_cmd_no_wr", n_wr - wr0, 32'd1);

      // Reset in the cycle after a data byte suppresses the pending strobe
      wr0 = n_wr;
      send_byte(8'hC0);
      send_byte(8'h77);
      reset = 1'b1;
      @(negedge clk);
      check_eq("rst_strobe_masked", {31'h0, gpo_wr_en}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_strobe_count", n_wr - wr0, 32'd0);

      // Reset in the middle of a stalled read
      tx_ready = 1'b0;
      tx0 = n_tx;
      send_byte(8'h80);
      @(negedge clk);
      check_eq("rst_rd_active", {31'h0, tx_valid}, 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_rd_tx_valid", {31'h0, tx_valid}, 32'd0);
      check_eq("rst_rd_busy", {31'h0, busy}, 32'd0);
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      send_byte(8'h00);
      repeat (5) @(posedge clk);
      #1;
      check_eq("nop_no_tx", n_tx - tx0, 32'd0);
      check_eq("nop_no_wr", n_wr - wr0, 32'd0);
      check_eq("nop_busy", {31'h0, busy}, 32'd0);

      check_eq("final_wr_queue", exp_wr.size(), 32'd0);
      check_eq("final_tx_queue", exp_tx.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
